sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 48 ++++
 rtl/sram_arbiter_if.sv | 40 ++++
 rtl/sram_arbiter.sv | 110 +++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, owner IDs,
// default widths and the idle strobe pattern.
package sram_arbiter_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int CPU_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_ACK,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobes_t;

  localparam strobes_t STROBES_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

  // Strobe pattern the SRAM sees while the FSM sits in a given state.
  function automatic strobes_t strobes_for(arb_state_t s);
    strobes_t r;
    r = STROBES_OFF;
    case (s)
      RD_ACCESS: begin
        r.ce_n = 1'b0;
        r.oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: r.ce_n = 1'b0;
      WR_PULSE: begin
        r.ce_n = 1'b0;
        r.we_n = 1'b0;
      end
      default: r = STROBES_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU-port and SRAM-pin bundle for the arbiter; the arbiter uses the slave
// modport, the CPU/SRAM environment uses the master modport.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [15:0]       if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [15:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_doe;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output ram_addr, ram_dout, ram_doe, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  ram_addr, ram_dout, ram_doe, ram_ce_n, ram_oe_n, ram_we_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between instruction fetch and data memory; the data
// port has fixed priority and every output, including the strobes, is a flop.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  strobes_t          strobes_q, strobes_d;
  logic              doe_q, doe_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_dout_q, ram_dout_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  // Outputs are derived from the next state so they line up with the state
  // they describe; requests are only looked at in IDLE, never in an ack state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.dm_req) begin
          owner_d    = OWN_DM;
          ram_addr_d = ADDR_W'(bus.dm_addr);
          if (bus.dm_we) begin
            ram_dout_d = bus.dm_wdata;
            state_d    = WR_SETUP;
          end else begin
            state_d = RD_ACCESS;
          end
        end else if (bus.if_req) begin
          owner_d    = OWN_IF;
          ram_addr_d = ADDR_W'(bus.if_addr);
          state_d    = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        state_d = RD_ACK;
        if (owner_q == OWN_DM) begin
          dm_rdata_d = bus.ram_din;
        end else begin
          if_rdata_d = bus.ram_din;
        end
      end
      RD_ACK:   state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    strobes_d = strobes_for(state_d);
    doe_d     = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    if_ack_d  = (state_d == RD_ACK) && (owner_d == OWN_IF);
    dm_ack_d  = ((state_d == RD_ACK) && (owner_d == OWN_DM)) || (state_d == WR_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      strobes_q  <= STROBES_OFF;
      doe_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      strobes_q  <= strobes_d;
      doe_q      <= doe_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.ram_ce_n = strobes_q.ce_n;
  assign bus.ram_oe_n = strobes_q.oe_n;
  assign bus.ram_we_n = strobes_q.we_n;
  assign bus.ram_doe  = doe_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an SRAM model on the pins, a transaction-level
// expectation queue checked every cycle, and directed plus random traffic.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        doe;
    logic [17:0] addr;
    logic [15:0] dout;
    logic        if_ack;
    logic        dm_ack;
    logic [15:0] if_rdata;
    logic [15:0] dm_rdata;
    logic        wr;
  } rec_t;

  function automatic logic [15:0] seedWord(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    if (a == 16'h0004) return 16'h00FF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // SRAM pin model: asynchronous read while selected, write on a clock edge
  // that sees the write pulse.
  logic [15:0] sram_mem [0:65535];
  bit sram_init = 1'b0;
  assign bus.ram_din = (!bus.ram_ce_n && !bus.ram_oe_n) ? sram_mem[bus.ram_addr[15:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 65536; i++) sram_mem[i] = seedWord(16'(i));
      sram_init = 1'b1;
    end
    if (!bus.ram_ce_n && !bus.ram_we_n && bus.ram_doe) sram_mem[bus.ram_addr[15:0]] = bus.ram_dout;
  end

  task automatic checkOutput(input string name, input logic [72:0] act, input logic [72:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: each granted transaction expands into the list of
  // per-cycle pin/ack values it must produce; an empty list means idle.
  logic [15:0] ref_mem [0:65535];
  bit          ref_init = 1'b0;
  rec_t        exp_q[$];
  rec_t        exp_rec;
  bit          cur_idle;
  logic [17:0] last_addr;
  logic [15:0] last_dout, last_ifr, last_dmr;

  function automatic rec_t idleRec();
    rec_t r;
    r.ce_n = 1'b1; r.oe_n = 1'b1; r.we_n = 1'b1; r.doe = 1'b0;
    r.addr = last_addr; r.dout = last_dout;
    r.if_ack = 1'b0; r.dm_ack = 1'b0;
    r.if_rdata = last_ifr; r.dm_rdata = last_dmr;
    r.wr = 1'b0;
    return r;
  endfunction

  function automatic void pushRead(input bit is_dm, input logic [15:0] a);
    rec_t r;
    logic [15:0] d;
    d = ref_mem[a];
    last_addr = {2'b00, a};
    r = idleRec();
    r.ce_n = 1'b0; r.oe_n = 1'b0;
    exp_q.push_back(r);
    if (is_dm) last_dmr = d; else last_ifr = d;
    r = idleRec();
    r.if_ack = !is_dm; r.dm_ack = is_dm;
    exp_q.push_back(r);
  endfunction

  function automatic void pushWrite(input logic [15:0] a, input logic [15:0] wd);
    rec_t r;
    last_addr = {2'b00, a};
    last_dout = wd;
    r = idleRec();
    r.ce_n = 1'b0; r.doe = 1'b1;
    exp_q.push_back(r);
    r.we_n = 1'b0;
    exp_q.push_back(r);
    r.we_n = 1'b1; r.dm_ack = 1'b1; r.wr = 1'b1;
    exp_q.push_back(r);
  endfunction

  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = seedWord(16'(i));
      ref_init = 1'b1;
    end
    if (rst) begin
      exp_q.delete();
      last_addr = '0; last_dout = '0; last_ifr = '0; last_dmr = '0;
      exp_rec = idleRec();
      cur_idle = 1'b1;
    end else begin
      if (cur_idle) begin
        if (bus.dm_req) begin
          if (bus.dm_we) pushWrite(bus.dm_addr, bus.dm_wdata);
          else pushRead(1'b1, bus.dm_addr);
        end else if (bus.if_req) begin
          pushRead(1'b0, bus.if_addr);
        end
      end
      if (exp_q.size() == 0) begin
        exp_rec = idleRec();
        cur_idle = 1'b1;
      end else begin
        exp_rec = exp_q.pop_front();
        cur_idle = 1'b0;
        if (exp_rec.wr) ref_mem[exp_rec.addr[15:0]] = exp_rec.dout;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    rec_t a;
    if (chk_en) begin
      a.ce_n = bus.ram_ce_n; a.oe_n = bus.ram_oe_n; a.we_n = bus.ram_we_n; a.doe = bus.ram_doe;
      a.addr = bus.ram_addr; a.dout = bus.ram_dout;
      a.if_ack = bus.if_ack; a.dm_ack = bus.dm_ack;
      a.if_rdata = bus.if_rdata; a.dm_rdata = bus.dm_rdata;
      a.wr = exp_rec.wr;
      checkOutput("cycle_model", a, exp_rec);
    end
  end

  task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                               input logic dwe, input logic [15:0] da, input logic [15:0] dwd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.dm_req = dr; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
  endtask

  function automatic logic [15:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 15));
  endfunction

  initial begin
    int n;
    int cel;
    int acks;
    int ack_at;
    bit we_low;
    bit saw_ack;

    rst = 1'b1;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_strobes", 73'({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_doe}), 73'(4'b1110));
    checkOutput("rst_addr_dout", 73'({bus.ram_addr, bus.ram_dout}), 73'(0));
    checkOutput("rst_acks_rdata", 73'({bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata}), 73'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Single fetch read of 0x0010; request held through the ack cycle.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("fetch_strobe", 73'({bus.ram_ce_n, bus.ram_oe_n, bus.ram_addr}), 73'({2'b00, 18'h00010}));
    @(negedge clk);
    checkOutput("fetch_ack", 73'({bus.if_ack, bus.if_rdata, bus.ram_oe_n}), 73'({1'b1, 16'hA5A5, 1'b1}));
    @(negedge clk);
    checkOutput("fetch_no_regrant", 73'({bus.ram_ce_n, bus.if_ack}), 73'(2'b10));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Data write to 0x8000 followed by a readback.
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h8000, 16'h1234);
    @(negedge clk);
    checkOutput("wr_setup", 73'({bus.ram_addr, bus.ram_ce_n, bus.ram_we_n, bus.ram_doe, bus.ram_dout}),
                73'({18'h08000, 3'b011, 16'h1234}));
    @(negedge clk);
    checkOutput("wr_pulse", 73'({bus.ram_we_n, bus.dm_ack}), 73'(2'b00));
    @(negedge clk);
    checkOutput("wr_hold", 73'({bus.ram_we_n, bus.dm_ack, bus.ram_ce_n}), 73'(3'b110));
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h8000, 16'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.dm_ack && n < 10);
    checkOutput("wr_readback", 73'({bus.dm_ack, bus.dm_rdata, 8'(n)}), 73'({1'b1, 16'h1234, 8'd3}));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Simultaneous requests: data read of 0x0004 must win.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0004, 16'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.dm_ack && n < 10);
    checkOutput("sim_dm_first", 73'({bus.dm_ack, bus.if_ack, bus.dm_rdata}), 73'({2'b10, 16'h00FF}));
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_ack && n < 10);
    checkOutput("sim_if_gap", 73'(n), 73'(3));
    checkOutput("sim_if_data", 73'(bus.if_rdata), 73'(seedWord(16'h0020)));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset while the write is in its setup cycle.
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'hBEEF);
    @(negedge clk);
    checkOutput("mw_setup", 73'({bus.ram_ce_n, bus.ram_we_n, bus.ram_doe}), 73'(3'b011));
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("mw_reset", 73'({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_doe, bus.dm_ack}), 73'(5'b11100));
    rst = 1'b0;
    we_low = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      we_low |= !bus.ram_we_n;
      saw_ack |= bus.dm_ack;
    end
    checkOutput("mw_quiet", 73'({we_low, saw_ack}), 73'(2'b00));
    checkOutput("mw_word_kept", 73'(sram_mem[16'h0030]), 73'(seedWord(16'h0030)));

    // Request held through its ack cycle, dropped in the following IDLE cycle.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    cel = 0;
    acks = 0;
    ack_at = -10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.ram_ce_n) cel++;
      if (bus.dm_ack) begin acks++; ack_at = i; end
      if (i == ack_at + 1) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checkOutput("hold_one_access", 73'({8'(cel), 8'(acks)}), 73'({8'd1, 8'd1}));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Random traffic from both ports, checked by the per-cycle model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (bus.if_req) begin
        if (bus.if_ack) begin
          if ($urandom_range(0, 1) == 1) bus.if_req = 1'b0;
          else bus.if_addr = randAddr();
        end
      end else if ($urandom_range(0, 9) < 4) begin
        bus.if_req = 1'b1;
        bus.if_addr = randAddr();
      end
      if (bus.dm_req) begin
        if (bus.dm_ack) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.dm_req = 1'b0;
          end else begin
            bus.dm_we = 1'($urandom_range(0, 1));
            bus.dm_addr = randAddr();
            bus.dm_wdata = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 9) < 3) begin
        bus.dm_req = 1'b1;
        bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = randAddr();
        bus.dm_wdata = 16'($urandom);
      end
    end

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
